board_controller: RTL and testbench

Sequencing controller for the 3x3 tic-tac-toe board. Turns single-cycle button pulses into cursor movement and mark placement, alternates turns, and scans the eight win lines sequentially after each move. It drives the per-cell `contents` and `cursor_on` inputs of the nine cell sprite instances, plus game status for the HUD/top level.

---
 rtl/board_controller.sv | 199 +++++++++++++++++++
 tb/tb_board_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/board_controller.sv
// Tic-tac-toe board sequencer: cursor movement, mark placement, turn alternation and a
// sequential eight-line win scan, with a blinking cursor/win-line highlight.
module board_controller #(
  parameter int unsigned BLINK_DIV = 12_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  input  logic        btn_new,
  output logic [17:0] contents,
  output logic [8:0]  cursor_on,
  output logic [3:0]  cursor_idx,
  output logic        turn,
  output logic [1:0]  state,
  output logic [1:0]  winner,
  output logic [2:0]  win_line
);

  localparam int unsigned CntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    StPlay  = 2'b00,
    StCheck = 2'b01,
    StWin   = 2'b10,
    StDraw  = 2'b11
  } state_e;

  function automatic logic [8:0] line_mask(input logic [2:0] k);
    logic [8:0] m;
    case (k)
      3'd0:    m = 9'b000_000_111;
      3'd1:    m = 9'b000_111_000;
      3'd2:    m = 9'b111_000_000;
      3'd3:    m = 9'b001_001_001;
      3'd4:    m = 9'b010_010_010;
      3'd5:    m = 9'b100_100_100;
      3'd6:    m = 9'b100_010_001;
      default: m = 9'b001_010_100;
    endcase
    return m;
  endfunction

  function automatic logic [8:0] cursor_mask(input state_e st, input logic [3:0] idx,
                                             input logic [2:0] wl, input logic phase);
    logic [8:0] m;
    m = '0;
    if (phase) begin
      case (st)
        StPlay, StCheck: m = 9'b1 << idx;
        StWin:           m = line_mask(wl);
        default:         m = '0;
      endcase
    end
    return m;
  endfunction

  state_e          r_state,     w_state_nxt;
  logic [17:0]     r_contents,  w_contents_nxt;
  logic [8:0]      r_cursor_on, w_cursor_on_nxt;
  logic [3:0]      r_idx,       w_idx_nxt;
  logic            r_turn,      w_turn_nxt;
  logic [1:0]      r_winner,    w_winner_nxt;
  logic [2:0]      r_win_line,  w_win_line_nxt;
  logic [3:0]      r_moves,     w_moves_nxt;
  logic [2:0]      r_line,      w_line_nxt;
  logic            r_phase,     w_phase_nxt;
  logic [CntW-1:0] r_blink_cnt, w_blink_cnt_nxt;

  logic [1:0] w_mark;
  logic [8:0] w_line_cells;
  logic       w_line_hit;
  logic       w_col0;
  logic       w_col2;

  assign w_mark       = {r_turn, ~r_turn};
  assign w_line_cells = line_mask(r_line);
  assign w_col0       = (r_idx == 4'd0) || (r_idx == 4'd3) || (r_idx == 4'd6);
  assign w_col2       = (r_idx == 4'd2) || (r_idx == 4'd5) || (r_idx == 4'd8);

  always_comb begin
    w_line_hit = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (w_line_cells[i] && (r_contents[2*i +: 2] != w_mark)) w_line_hit = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_contents_nxt  = r_contents;
    w_idx_nxt       = r_idx;
    w_turn_nxt      = r_turn;
    w_winner_nxt    = r_winner;
    w_win_line_nxt  = r_win_line;
    w_moves_nxt     = r_moves;
    w_line_nxt      = r_line;
    w_phase_nxt     = r_phase;
    w_blink_cnt_nxt = r_blink_cnt + 1'b1;

    if (r_blink_cnt == CntMax) begin
      w_blink_cnt_nxt = '0;
      w_phase_nxt     = ~r_phase;
    end

    if (btn_new) begin
      w_state_nxt     = StPlay;
      w_contents_nxt  = '0;
      w_idx_nxt       = 4'd4;
      w_turn_nxt      = 1'b0;
      w_winner_nxt    = 2'b00;
      w_win_line_nxt  = 3'd0;
      w_moves_nxt     = 4'd0;
      w_line_nxt      = 3'd0;
      w_phase_nxt     = 1'b1;
      w_blink_cnt_nxt = '0;
    end else begin
      case (r_state)
        StPlay: begin
          if (btn_sel) begin
            if (r_contents[2*int'(r_idx) +: 2] == 2'b00) begin
              w_contents_nxt[2*int'(r_idx) +: 2] = w_mark;
              w_moves_nxt = r_moves + 4'd1;
              w_line_nxt  = 3'd0;
              w_state_nxt = StCheck;
            end
          end else if (btn_up || btn_down || btn_left || btn_right) begin
            if (btn_up)        w_idx_nxt = (r_idx < 4'd3) ? r_idx + 4'd6 : r_idx - 4'd3;
            else if (btn_down) w_idx_nxt = (r_idx > 4'd5) ? r_idx - 4'd6 : r_idx + 4'd3;
            else if (btn_left) w_idx_nxt = w_col0 ? r_idx + 4'd2 : r_idx - 4'd1;
            else               w_idx_nxt = w_col2 ? r_idx - 4'd2 : r_idx + 4'd1;
            w_phase_nxt     = 1'b1;
            w_blink_cnt_nxt = '0;
          end
        end
        StCheck: begin
          if (w_line_hit) begin
            w_state_nxt    = StWin;
            w_winner_nxt   = w_mark;
            w_win_line_nxt = r_line;
          end else if (r_line == 3'd7) begin
            if (r_moves == 4'd9) begin
              w_state_nxt = StDraw;
            end else begin
              w_state_nxt = StPlay;
              w_turn_nxt  = ~r_turn;
            end
          end else begin
            w_line_nxt = r_line + 3'd1;
          end
        end
        default: ;
      endcase
    end

    // Highlight is registered from next-state values so it moves in step with the cursor.
    w_cursor_on_nxt = cursor_mask(w_state_nxt, w_idx_nxt, w_win_line_nxt, w_phase_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StPlay;
      r_contents  <= '0;
      r_cursor_on <= '0;
      r_idx       <= 4'd4;
      r_turn      <= 1'b0;
      r_winner    <= 2'b00;
      r_win_line  <= 3'd0;
      r_moves     <= 4'd0;
      r_line      <= 3'd0;
      r_phase     <= 1'b1;
      r_blink_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_contents  <= w_contents_nxt;
      r_cursor_on <= w_cursor_on_nxt;
      r_idx       <= w_idx_nxt;
      r_turn      <= w_turn_nxt;
      r_winner    <= w_winner_nxt;
      r_win_line  <= w_win_line_nxt;
      r_moves     <= w_moves_nxt;
      r_line      <= w_line_nxt;
      r_phase     <= w_phase_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
    end
  end

  assign contents   = r_contents;
  assign cursor_on  = r_cursor_on;
  assign cursor_idx = r_idx;
  assign turn       = r_turn;
  assign state      = r_state;
  assign winner     = r_winner;
  assign win_line   = r_win_line;

endmodule

// File: tb/tb_board_controller.sv
// Directed bench for board_controller: expected outputs are queued as each step is driven and
// compared after the following clock edge.
module tb_board_controller;

  localparam int unsigned BlinkDiv = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        btn_sel = 1'b0, btn_new = 1'b0;
  logic [17:0] contents;
  logic [8:0]  cursor_on;
  logic [3:0]  cursor_idx;
  logic        turn;
  logic [1:0]  state;
  logic [1:0]  winner;
  logic [2:0]  win_line;

  always #5 clk = ~clk;

  board_controller #(.BLINK_DIV(BlinkDiv)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_sel   (btn_sel),
    .btn_new   (btn_new),
    .contents  (contents),
    .cursor_on (cursor_on),
    .cursor_idx(cursor_idx),
    .turn      (turn),
    .state     (state),
    .winner    (winner),
    .win_line  (win_line)
  );

  typedef struct {
    string       tag;
    int          sig;
    logic [17:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;

  // Expected-value model, set explicitly by the directed sequence.
  logic [17:0] m_c;
  logic [3:0]  m_idx;
  logic        m_turn;
  logic [1:0]  m_st;
  logic [1:0]  m_win;
  logic [2:0]  m_wl;
  int          m_e;    // edges since the blink phase was last forced visible
  bit          m_rst;

  function automatic logic [8:0] wl_mask(input logic [2:0] k);
    logic [8:0] t[8];
    t = '{9'b000000111, 9'b000111000, 9'b111000000, 9'b001001001,
          9'b010010010, 9'b100100100, 9'b100010001, 9'b001010100};
    return t[k];
  endfunction

  function automatic logic [8:0] exp_cur();
    bit ph;
    ph = ((m_e / int'(BlinkDiv)) % 2) == 0;
    if (m_rst || !ph) return 9'd0;
    case (m_st)
      2'd0, 2'd1: return 9'd1 << m_idx;
      2'd2:       return wl_mask(m_wl);
      default:    return 9'd0;
    endcase
  endfunction

  function automatic logic [17:0] dut_sig(input int s);
    case (s)
      0:       return contents;
      1:       return {9'd0, cursor_on};
      2:       return {14'd0, cursor_idx};
      3:       return {17'd0, turn};
      4:       return {16'd0, state};
      5:       return {16'd0, winner};
      default: return {15'd0, win_line};
    endcase
  endfunction

  task automatic push(input string tag);
    sb.push_back('{{tag, ".contents"},  0, m_c});
    sb.push_back('{{tag, ".cursor_on"}, 1, {9'd0, exp_cur()}});
    sb.push_back('{{tag, ".idx"},       2, {14'd0, m_idx}});
    sb.push_back('{{tag, ".turn"},      3, {17'd0, m_turn}});
    sb.push_back('{{tag, ".state"},     4, {16'd0, m_st}});
    sb.push_back('{{tag, ".winner"},    5, {16'd0, m_win}});
    sb.push_back('{{tag, ".win_line"},  6, {15'd0, m_wl}});
  endtask

  task automatic drain();
    exp_t e;
    logic [17:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = dut_sig(e.sig);
      n_vec++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic model_reset();
    m_c = '0; m_idx = 4'd4; m_turn = 1'b0; m_st = 2'd0; m_win = 2'd0; m_wl = 3'd0;
  endtask

  // btns = {new, sel, up, down, left, right}
  task automatic apply(input string tag, input logic [5:0] btns, input bit blink_rst);
    m_e = blink_rst ? 0 : m_e + 1;
    push(tag);
    {btn_new, btn_sel, btn_up, btn_down, btn_left, btn_right} = btns;
    @(posedge clk);
    #1;
    {btn_new, btn_sel, btn_up, btn_down, btn_left, btn_right} = 6'b0;
    drain();
  endtask

  // dir: 0 up, 1 down, 2 left, 3 right
  task automatic mv(input string tag, input int dir);
    int r, c;
    r = int'(m_idx) / 3;
    c = int'(m_idx) % 3;
    case (dir)
      0:       r = (r == 0) ? 2 : r - 1;
      1:       r = (r == 2) ? 0 : r + 1;
      2:       c = (c == 0) ? 2 : c - 1;
      default: c = (c == 2) ? 0 : c + 1;
    endcase
    m_idx = 4'(3 * r + c);
    apply(tag, 6'b001000 >> dir, 1'b1);
  endtask

  task automatic goto(input int target);
    for (int i = 0; i < 2; i++) if (int'(m_idx) % 3 != target % 3) mv("goto_r", 3);
    for (int i = 0; i < 2; i++) if (int'(m_idx) / 3 != target / 3) mv("goto_d", 1);
  endtask

  task automatic place(input string tag, input int win_k, input bit draw);
    logic [1:0] mark;
    mark = m_turn ? 2'b10 : 2'b01;
    m_c[2*int'(m_idx) +: 2] = mark;
    m_st = 2'd1;
    apply({tag, "_sel"}, 6'b010000, 1'b0);
    for (int j = 1; j <= 8; j++) begin
      if (win_k >= 0 && j == win_k + 1) begin
        m_st = 2'd2; m_win = mark; m_wl = 3'(win_k);
        apply({tag, "_win"}, 6'b0, 1'b0);
        break;
      end
      if (j == 8) begin
        if (draw) m_st = 2'd3;
        else begin
          m_st = 2'd0; m_turn = ~m_turn;
        end
      end
      apply({tag, "_chk"}, 6'b0, 1'b0);
    end
  endtask

  initial begin
    model_reset();
    m_rst = 1'b1;
    m_e = 0;
    #12;
    push("in_reset");
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    m_rst = 1'b0;
    apply("released", 6'b0, 1'b0);

    // Movement and all four wrap-arounds
    mv("left_4", 2);
    mv("up_3", 0);
    mv("left_wrap", 2);
    mv("up_wrap", 0);
    for (int i = 0; i < 5; i++) apply("blink_idle", 6'b0, 1'b0);
    mv("down_wrap", 1);
    mv("right_wrap", 3);

    // Place X at centre, then try the occupied cell as O
    goto(4);
    place("x4", -1, 1'b0);
    apply("occupied", 6'b010000, 1'b0);

    // sel+up priority, dropped pulse in CHECK, abort in 3rd CHECK cycle
    model_reset();
    apply("new1", 6'b100000, 1'b1);
    m_c[9:8] = 2'b01;
    m_st = 2'd1;
    apply("sel_up", 6'b011000, 1'b0);
    apply("chk_drop", 6'b000001, 1'b0);
    apply("chk2", 6'b0, 1'b0);
    model_reset();
    apply("abort", 6'b100000, 1'b1);

    // X wins on diagonal {0,4,8}
    goto(0); place("g1x0", -1, 1'b0);
    goto(1); place("g1o1", -1, 1'b0);
    goto(4); place("g1x4", -1, 1'b0);
    goto(2); place("g1o2", -1, 1'b0);
    goto(8); place("g1x8", 6, 1'b0);
    apply("win_sel", 6'b010000, 1'b0);
    apply("win_left", 6'b000010, 1'b0);
    for (int i = 0; i < 6; i++) apply("win_blink", 6'b0, 1'b0);

    // Draw
    model_reset();
    apply("new2", 6'b100000, 1'b1);
    goto(0); place("d_x0", -1, 1'b0);
    goto(1); place("d_o1", -1, 1'b0);
    goto(2); place("d_x2", -1, 1'b0);
    goto(4); place("d_o4", -1, 1'b0);
    goto(3); place("d_x3", -1, 1'b0);
    goto(5); place("d_o5", -1, 1'b0);
    goto(7); place("d_x7", -1, 1'b0);
    goto(6); place("d_o6", -1, 1'b0);
    goto(8); place("d_x8", -1, 1'b1);
    apply("draw_hold", 6'b001000, 1'b0);

    // Asynchronous reset mid-game
    model_reset();
    apply("new3", 6'b100000, 1'b1);
    mv("pre_rst", 3);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    m_rst = 1'b1;
    m_e = 0;
    push("async_rst");
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    m_rst = 1'b0;
    apply("released2", 6'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
